// File: rtl/rock_stepper.sv
// Rocking motion sequencer: each step tick moves a signed position in a triangle
// sweep between -amp_l and +amp_l and drives a one-hot 4-phase full-step coil pattern.
module rock_stepper #(
    parameter int AMP_W = 8,
    parameter int POS_W = 9
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    Tick,
    input  logic                    Enable,
    input  logic [AMP_W-1:0]        Amplitude,
    output logic [3:0]              Phase,
    output logic signed [POS_W-1:0] Position,
    output logic                    Dir,
    output logic                    Busy,
    output logic                    CycleDone
);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        REV,
        HOME
    } state_t;

    localparam logic signed [POS_W-1:0] ONE = POS_W'(1);

    state_t                    state, state_nxt;
    logic [AMP_W-1:0]          amp_l, amp_nxt;
    logic signed [POS_W-1:0]   pos_nxt;
    logic signed [POS_W-1:0]   amp_s;
    logic [3:0]                phase_nxt;
    logic                      dir_nxt;
    logic                      done_nxt;

    // The latched bound is at most 2^AMP_W-1, so zero-extending it into POS_W bits is exact.
    assign amp_s = $signed({1'b0, amp_l});

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nxt = state;
        pos_nxt   = Position;
        amp_nxt   = amp_l;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (Enable) begin
                    state_nxt = FWD;
                    amp_nxt   = Amplitude;
                end
            end

            FWD: begin
                if (!Enable) begin
                    state_nxt = HOME;
                end else if (Tick && (amp_l != '0)) begin
                    if (Position == amp_s) begin
                        state_nxt = REV;
                        pos_nxt   = Position - ONE;
                    end else begin
                        pos_nxt = Position + ONE;
                        // Centre crossing: a full period ends and a new bound is accepted.
                        if (Position == -ONE) begin
                            amp_nxt  = Amplitude;
                            done_nxt = 1'b1;
                        end
                    end
                end
            end

            REV: begin
                if (!Enable) begin
                    state_nxt = HOME;
                end else if (Tick) begin
                    if (Position == -amp_s) begin
                        state_nxt = FWD;
                        pos_nxt   = Position + ONE;
                    end else begin
                        pos_nxt = Position - ONE;
                    end
                end
            end

            HOME: begin
                if (Position == '0) begin
                    state_nxt = IDLE;
                end else if (Tick) begin
                    pos_nxt = Position[POS_W-1] ? Position + ONE : Position - ONE;
                end
            end

            default: state_nxt = IDLE;
        endcase

        phase_nxt = 4'b0000;
        if (state_nxt != IDLE) begin
            case (pos_nxt[1:0])
                2'b00:   phase_nxt = 4'b0001;
                2'b01:   phase_nxt = 4'b0010;
                2'b10:   phase_nxt = 4'b0100;
                default: phase_nxt = 4'b1000;
            endcase
        end

        dir_nxt = (state_nxt == FWD) || ((state_nxt == HOME) && pos_nxt[POS_W-1]);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Position  <= '0;
            amp_l     <= '0;
            Phase     <= 4'b0000;
            Dir       <= 1'b0;
            Busy      <= 1'b0;
            CycleDone <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            Position  <= pos_nxt;
            amp_l     <= amp_nxt;
            Phase     <= phase_nxt;
            Dir       <= dir_nxt;
            Busy      <= (state_nxt != IDLE);
            CycleDone <= done_nxt;
        end
    end

endmodule
